// File: rtl/alu_op_driver.sv
// Command FIFO plus a sequencer that drives an external 4-bit ALU, then captures S/C2 into a result
// register and a chaining accumulator. Define ALU_DRV_STATS_EN to add capture/carry counters.
module alu_op_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_cin,
  input  logic       cmd_acc,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_cin,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_s,
  input  logic       alu_cout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_s,
  output logic       res_cout,
  output logic [3:0] acc,
`ifdef ALU_DRV_STATS_EN
  output logic [7:0] stat_ops,
  output logic [7:0] stat_carry,
`endif
  output logic       busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       acc;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StDrive, StCapture, StResult} state_t;

  cmd_t            r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  state_t          r_state;
  logic [3:0]      r_settle;
  logic [3:0]      r_alu_a;
  logic [3:0]      r_alu_b;
  logic            r_alu_cin;
  logic [1:0]      r_alu_op;
  logic            r_res_valid;
  logic [3:0]      r_res_s;
  logic            r_res_cout;
  logic [3:0]      r_acc;
`ifdef ALU_DRV_STATS_EN
  logic [7:0]      r_stat_ops;
  logic [7:0]      r_stat_carry;
`endif

  logic            w_push;
  logic            w_pop;
  cmd_t            w_cmd;
  cmd_t            w_head;

  assign w_cmd     = '{op: cmd_op, a: cmd_a, b: cmd_b, cin: cmd_cin, acc: cmd_acc};
  assign w_head    = r_mem[r_rptr];
  assign cmd_ready = (r_count != CntW'(FIFO_DEPTH));
  assign w_push    = cmd_valid & cmd_ready;
  // Pops only from IDLE, so a pending result always blocks the next command.
  assign w_pop     = (r_state == StIdle) && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_settle    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_cin   <= 1'b0;
      r_alu_op    <= '0;
      r_res_valid <= 1'b0;
      r_res_s     <= '0;
      r_res_cout  <= 1'b0;
      r_acc       <= '0;
`ifdef ALU_DRV_STATS_EN
      r_stat_ops   <= '0;
      r_stat_carry <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_alu_a   <= w_head.acc ? r_acc : w_head.a;
            r_alu_b   <= w_head.b;
            r_alu_cin <= w_head.cin;
            r_alu_op  <= w_head.op;
            r_settle  <= '0;
            r_state   <= StDrive;
          end
        end
        StDrive: begin
          // Counter starts at zero, so pop-to-valid latency is SETTLE_CYC+2.
          if (r_settle == 4'(SETTLE_CYC)) begin
            r_state <= StCapture;
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        StCapture: begin
          r_res_s     <= alu_s;
          r_res_cout  <= alu_cout;
          r_acc       <= alu_s;
          r_res_valid <= 1'b1;
          r_state     <= StResult;
`ifdef ALU_DRV_STATS_EN
          if (r_stat_ops != 8'hFF) r_stat_ops <= r_stat_ops + 8'd1;
          if (alu_cout && (r_stat_carry != 8'hFF)) r_stat_carry <= r_stat_carry + 8'd1;
`endif
        end
        StResult: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_cin   = r_alu_cin;
  assign alu_op    = r_alu_op;
  assign res_valid = r_res_valid;
  assign res_s     = r_res_s;
  assign res_cout  = r_res_cout;
  assign acc       = r_acc;
  assign busy      = (r_state != StIdle) || (r_count != '0);
`ifdef ALU_DRV_STATS_EN
  assign stat_ops   = r_stat_ops;
  assign stat_carry = r_stat_carry;
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// Self-checking bench for alu_op_driver: behavioural ALU, command-order reference model,
// randomized traffic plus directed latency, chaining, backpressure and reset scenarios.
module tb_alu_op_driver;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 1;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_cin;
  logic       cmd_acc;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic [1:0] alu_op;
  logic [3:0] alu_s;
  logic       alu_cout;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_s;
  logic       res_cout;
  logic [3:0] acc;
  logic       busy;
`ifdef ALU_DRV_STATS_EN
  logic [7:0] stat_ops;
  logic [7:0] stat_carry;
`endif

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];   // {cout, s} per accepted command, in order
  logic [3:0] m_acc;

  alu_op_driver #(.FIFO_DEPTH(DEPTH), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a),
    .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_acc(cmd_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_s(alu_s), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_s(res_s), .res_cout(res_cout),
    .acc(acc),
`ifdef ALU_DRV_STATS_EN
    .stat_ops(stat_ops), .stat_carry(stat_carry),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: sub is A + ~B + Cin with C2 as the carry out.
  function automatic logic [4:0] alu_fn(input logic [1:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic cin);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b} + {4'b0, cin};
      2'd1:    return {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  always_comb begin
    {alu_cout, alu_s} = alu_fn(alu_op, alu_a, alu_b, alu_cin);
  end

  task automatic model_push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                            input logic cin, input logic accsel);
    logic [4:0] r;
    r = alu_fn(op, accsel ? m_acc : a, b, cin);
    exp_q.push_back(r);
    m_acc = r[3:0];
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic cin, input logic accsel);
    bit ok = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_acc = accsel;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_push(op, a, b, cin, accsel);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_result(input int delay);
    bit got = 0;
    logic [4:0] e;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL result_timeout: res_valid stayed %0b, required 1", res_valid);
      return;
    end
    repeat (delay) @(negedge clk);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1f;
    checks++;
    if ({res_cout, res_s} !== e) begin
      errors++;
      $display("FAIL result: got cout=%0b s=%h, required cout=%0b s=%h",
               res_cout, res_s, e[4], e[3:0]);
    end
    checks++;
    if (acc !== e[3:0]) begin
      errors++;
      $display("FAIL acc: got %h, required %h", acc, e[3:0]);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL res_drop: res_valid got %0b, required 0", res_valid);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({alu_a, alu_b, alu_cin, alu_op, res_valid, res_s, res_cout, acc, busy} !== '0) begin
      errors++;
      $display("FAIL %s: alu_a=%h alu_b=%h cin=%b op=%h rv=%b s=%h co=%b acc=%h busy=%b, required all 0",
               tag, alu_a, alu_b, alu_cin, alu_op, res_valid, res_s, res_cout, acc, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    m_acc = '0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b, required 1 and 0", cmd_ready, busy);
    end
  endtask

  task automatic test_single_add();
    int cyc = 0;
    push_cmd(2'd0, 4'd3, 4'd4, 1'b0, 1'b0);
    while (cyc < 50) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) begin
        checks++;
        if (alu_a !== 4'd3 || alu_b !== 4'd4 || alu_op !== 2'd0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL drive_add: alu_a=%h alu_b=%h op=%h busy=%b, required 3 4 0 1",
                   alu_a, alu_b, alu_op, busy);
        end
      end
      if (res_valid) break;
    end
    checks++;
    if (cyc != SETTLE + 3) begin
      errors++;
      $display("FAIL latency: got %0d cycles from push, required %0d", cyc, SETTLE + 3);
    end
    get_result(0);
  endtask

  task automatic test_chain();
    push_cmd(2'd0, 4'd9, 4'd9, 1'b0, 1'b0);
    get_result(0);
    push_cmd(2'd3, 4'($urandom_range(0, 15)), 4'hC, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (alu_a !== 4'd2 || alu_b !== 4'hC || alu_op !== 2'd3) begin
      errors++;
      $display("FAIL chain_operand: alu_a=%h alu_b=%h op=%h, required 2 c 3", alu_a, alu_b, alu_op);
    end
    get_result(0);
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [6];
    logic [3:0] as  [6];
    logic [3:0] bs  [6];
    logic       cs  [6];
    logic       ac  [6];
    logic [4:0] first;
    int accepted = 0;
    bit rdy;
    for (int i = 0; i < 6; i++) begin
      ops[i] = 2'($urandom_range(0, 3)); as[i] = 4'($urandom_range(0, 15));
      bs[i]  = 4'($urandom_range(0, 15)); cs[i] = 1'($urandom_range(0, 1));
      ac[i]  = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    res_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (accepted < 6) begin
        cmd_valid = 1'b1; cmd_op = ops[accepted]; cmd_a = as[accepted];
        cmd_b = bs[accepted]; cmd_cin = cs[accepted]; cmd_acc = ac[accepted];
      end else begin
        cmd_valid = 1'b0;
      end
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy && cmd_valid) begin
        model_push(ops[accepted], as[accepted], bs[accepted], cs[accepted], ac[accepted]);
        accepted++;
      end
    end
    #1 cmd_valid = 1'b0;
    checks++;
    if (accepted != DEPTH + 1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: accepted %0d cmd_ready=%b, required %0d and 0",
               accepted, cmd_ready, DEPTH + 1);
    end
    first = exp_q[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || {res_cout, res_s} !== first || alu_a !== as[0] ||
          alu_b !== bs[0] || alu_op !== ops[0] || alu_cin !== cs[0]) begin
        errors++;
        $display("FAIL hold: rv=%b res=%h alu=%h/%h/%h/%b, required 1 %h %h/%h/%h/%b",
                 res_valid, {res_cout, res_s}, alu_a, alu_b, alu_op, alu_cin,
                 first, as[0], bs[0], ops[0], cs[0]);
      end
    end
    for (int i = 0; i < accepted; i++) get_result($urandom_range(0, 2));
    for (int i = accepted; i < 6; i++) begin
      push_cmd(ops[i], as[i], bs[i], cs[i], ac[i]);
      get_result(0);
    end
  endtask

  task automatic test_reset_mid();
    push_cmd(2'd0, 4'd5, 4'd6, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    exp_q.delete();
    m_acc = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL after_reset: res_valid=%b busy=%b, required 0 0", res_valid, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++)
        push_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int j = 0; j < k; j++) get_result($urandom_range(0, 3));
    end
  endtask

`ifdef ALU_DRV_STATS_EN
  task automatic test_stats();
    for (int n = 0; n < 300; n++) begin
      push_cmd(2'd0, 4'd8, 4'd8, 1'b0, 1'b0);
      get_result(0);
    end
    checks++;
    if (stat_ops !== 8'd255 || stat_carry !== 8'd255) begin
      errors++;
      $display("FAIL stats: ops=%0d carry=%0d, required 255 255", stat_ops, stat_carry);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_cin = 1'b0; cmd_acc = 1'b0; res_ready = 1'b0; m_acc = '0;
    test_reset();
    test_single_add();
    test_chain();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef ALU_DRV_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
